// File: rtl/instr_fetch.sv
// instr_fetch: PC/ROM fetch stage with stall, branch redirect and HALT freeze; IFETCH_PERF_CNT_EN enables fetch_cnt
module instr_fetch #(
  parameter int ADDR_W = 16,
  parameter int INSTR_W = 27
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic [ADDR_W-1:0]  pc_addr,
  input  logic [INSTR_W-1:0] prom_data,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               if_valid,
  output logic               halted,
  output logic [31:0]        fetch_cnt
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] pc_nx, if_pc_nx;
  logic [INSTR_W-1:0] if_instr_nx;
  logic if_valid_nx, load, is_halt;
  assign is_halt = prom_data[26] && prom_data[25:22] == 4'b0000;
  assign halted = state == HALTED;
  always_comb begin
    state_nx = state;
    pc_nx = pc_addr;
    if_instr_nx = if_instr;
    if_pc_nx = if_pc;
    if_valid_nx = if_valid;
    load = 1'b0;
    if (state == RUN) begin
      if (br_taken) begin
        pc_nx = br_target;
        if_instr_nx = '0;
        if_valid_nx = 1'b0;
      end else if (!stall) begin
        load = 1'b1;
        if_instr_nx = prom_data;
        if_pc_nx = pc_addr;
        if_valid_nx = 1'b1;
        pc_nx = is_halt ? pc_addr : pc_addr + ADDR_W'(1);
        state_nx = is_halt ? HALTED : RUN;
      end
    end else if (!stall) begin
      if_instr_nx = '0;
      if_valid_nx = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc_addr <= '0;
      if_instr <= '0;
      if_pc <= '0;
      if_valid <= 1'b0;
    end else begin
      state <= state_nx;
      pc_addr <= pc_nx;
      if_instr <= if_instr_nx;
      if_pc <= if_pc_nx;
      if_valid <= if_valid_nx;
    end
  end
`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) fetch_cnt <= '0;
    else if (load) fetch_cnt <= fetch_cnt + 32'd1;
  end
`else
  assign fetch_cnt = '0;
  logic unused_load;
  assign unused_load = load;
`endif
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 27-bit-instruction core. Holds the program counter, drives the address of the combinational program ROM, captures the returned instruction word into the IF/ID pipeline register, and presents it to decode with a valid flag. Also handles stall, branch redirect/flush from downstream, and HALT detection, which freezes fetch until reset.

## Interface
- ADDR_W, 16, program counter / ROM address width
- INSTR_W, 27, instruction word width
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  decode back-pressure; hold PC and IF/ID register
- br_taken  in  1  redirect request from branch-resolve stage (single-cycle pulse)
- br_target  in  ADDR_W  absolute redirect address, valid with br_taken
- pc_addr  out  ADDR_W  ROM address (= PC register, no combinational path from inputs)
- prom_data  in  INSTR_W  ROM read data, combinational from pc_addr
- if_instr  out  INSTR_W  registered instruction to decode
- if_pc  out  ADDR_W  address of if_instr
- if_valid  out  1  if_instr is a real, non-flushed instruction
- halted  out  1  fetch stopped on HALT
- fetch_cnt  out  32  count of valid instructions delivered (see Configuration)

## Operation
- Instruction format: bit 26 immediate flag, bits 25:22 opcode, 21:19 rd, 18:16 rs, 15:0 imm/rt. HALT = bit 26 = 1, opcode 4'b0000. NOP = all zeros.
- FSM: RUN, HALTED. Reset -> RUN.
- RUN, per edge, priority order:
  - br_taken=1: PC <= br_target; if_instr <= NOP; if_valid <= 0; stall ignored. HALT word on prom_data this cycle is wrong-path: no halt.
  - stall=1: PC, if_instr, if_pc, if_valid, state all hold.
  - otherwise: if_instr <= prom_data; if_pc <= PC; if_valid <= 1; PC <= PC+1 (mod 2^ADDR_W, 16'hFFFF wraps to 0). If prom_data is HALT: state <= HALTED, PC not incremented.
- HALTED: PC frozen at HALT address; if_valid <= 0 and if_instr <= NOP on first edge unless stall=1 (then HALT held until stall drops, then cleared); br_taken and stall otherwise ignored; exit only by rst.
- halted = (state == HALTED).
- rst overrides everything in any state, mid-stall or mid-branch.

## Timing
- Reset values: PC 0, pc_addr 0, if_instr 0, if_pc 0, if_valid 0, halted 0, fetch_cnt 0, state RUN.
- Fetch latency: 1 cycle — word at pc_addr in cycle N appears on if_instr in N+1.
- Throughput: one instruction per cycle without stall/redirect.
- Redirect penalty: 1 bubble; first target instruction valid 2 edges after br_taken edge.
- halted asserts the cycle after HALT word is captured (same cycle if_valid=1 with HALT on if_instr).

## Configuration
- IFETCH_PERF_CNT_EN defined: fetch_cnt increments by 1 on every edge where if_valid is loaded with 1 (not on hold under stall), 32-bit wrap, reset to 0.
- Not defined: counter logic omitted; fetch_cnt tied to 0.

## Test plan
- Reset then release with ROM words 0..3 loaded -> edges 1..4 give if_pc 0,1,2,3, if_valid=1, if_instr = ROM[k]; pc_addr 1..4.
- stall=1 for 3 cycles while if_pc=2 -> if_instr/if_pc/pc_addr unchanged; on release if_pc=3 next edge; fetch_cnt unchanged during stall (macro on).
- br_taken=1, br_target=33 while PC=66 -> next edge if_valid=0, pc_addr=33; following edge if_pc=33, if_valid=1.
- HALT (27'b1_0000_000_000_0…0) at address 69 -> if_pc=69 with if_valid=1, halted=1; later cycles if_valid=0, pc_addr=69 fixed, br_taken ignored; rst returns pc_addr=0, halted=0.
- br_taken coincident with HALT on prom_data -> no halt, pc_addr=br_target.
- PC forced to 16'hFFFF via br_target -> next fetch if_pc=16'hFFFF, pc_addr wraps to 0.
